// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative data cache.
package cache_pkg;

    localparam int DEF_WAYS    = 2;
    localparam int DEF_SETS    = 64;
    localparam int DEF_TAG_W   = 10;
    localparam int DEF_INDEX_W = $clog2(DEF_SETS);
    localparam int DEF_PLRU_W  = DEF_WAYS - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } cache_state_e;

    // Saturating 32-bit increment used by the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/assoc_cache_ctrl_plru_tree.sv
// Tree pseudo-LRU for one set: picks a victim way and computes the
// updated tree bits after an access. Node n has children 2n+1 / 2n+2.
module plru_tree #(
    parameter int WAYS   = 2,
    parameter int PLRU_W = WAYS - 1,
    parameter int WAY_W  = $clog2(WAYS)
) (
    input  logic [PLRU_W-1:0] plru_i,
    input  logic [WAYS-1:0]   valid_i,
    input  logic [WAY_W-1:0]  acc_way_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [PLRU_W-1:0] plru_o
);

    // Victim: lowest invalid way first, otherwise follow the tree (bit 0 = left).
    always_comb begin : victim_walk
        int node;
        int v;
        int d;
        logic [WAY_W-1:0] first_inv;
        node      = 0;
        v         = 0;
        d         = 0;
        first_inv = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            first_inv = valid_i[w] ? first_inv : WAY_W'(w);
        end
        if (!(&valid_i)) begin
            victim_o = first_inv;
        end else begin
            for (int l = 0; l < WAY_W; l++) begin
                d = 0;
                for (int n = 0; n < PLRU_W; n++) begin
                    d = (n == node) ? int'(plru_i[n]) : d;
                end
                v    = v * 2 + d;
                node = 2 * node + 1 + d;
            end
            victim_o = WAY_W'(v);
        end
    end

    // Update: every node on the accessed way's path points away from it.
    always_comb begin : tree_update
        int node;
        int a;
        int d;
        plru_o = plru_i;
        node   = 0;
        a      = int'(acc_way_i);
        d      = 0;
        for (int l = 0; l < WAY_W; l++) begin
            d = (a >> (WAY_W - 1 - l)) & 1;
            for (int n = 0; n < PLRU_W; n++) begin
                plru_o[n] = (n == node) ? (d == 0) : plru_o[n];
            end
            node = 2 * node + 1 + d;
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way write-through, no-write-allocate data cache in front of the SRAM
// controller. Define CACHE_STATS_EN to add saturating hit/miss counters.
module assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic        flush,
    output logic [31:0] readData,
    output logic        ready,
    output logic [31:0] sramAddress,
    output logic [31:0] sramWriteData,
    output logic        sramWrEn,
    output logic        sramRdEn,
    input  logic [63:0] sramReadData,
    input  logic        sramReady
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int PLRU_W  = WAYS - 1;
    localparam int WAY_W   = $clog2(WAYS);

    logic [63:0]       data_q  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [PLRU_W-1:0] plru_q  [SETS];

    cache_state_e state_q, state_d;

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [WAYS-1:0]    hit_vec_s;
    logic               hit_s;
    logic [WAY_W-1:0]   hit_way_s;
    logic [WAY_W-1:0]   victim_s;
    logic [WAY_W-1:0]   acc_way_s;
    logic [PLRU_W-1:0]  plru_next_s;
    logic [63:0]        hit_line_s;
    logic [63:0]        wr_line_s;
    logic [31:0]        hit_word_s;
    logic [31:0]        fill_word_s;
    logic               flush_all_s;
    logic               plru_we_s;
    logic               fill_we_s;
    logic               wr_hit_we_s;
    logic               hit_inc_s;
    logic               miss_inc_s;

    assign idx_s         = address[INDEX_W+2:3];
    assign tag_s         = address[INDEX_W+3 +: TAG_W];
    assign sramAddress   = address;
    assign sramWriteData = writeData;

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_q[idx_s][w] && (tag_q[w][idx_s] == tag_s);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
        end
        hit_s = |hit_vec_s;
    end

    assign hit_line_s  = data_q[hit_way_s][idx_s];
    assign hit_word_s  = address[2] ? hit_line_s[63:32] : hit_line_s[31:0];
    assign fill_word_s = address[2] ? sramReadData[63:32] : sramReadData[31:0];
    assign wr_line_s   = address[2] ? {writeData, hit_line_s[31:0]}
                                    : {hit_line_s[63:32], writeData};
    // A fill trains the tree on the victim; every other access on the hit way.
    assign acc_way_s   = (state_q == RD_MISS) ? victim_s : hit_way_s;

    plru_tree #(
        .WAYS   (WAYS),
        .PLRU_W (PLRU_W),
        .WAY_W  (WAY_W)
    ) u_plru (
        .plru_i    (plru_q[idx_s]),
        .valid_i   (valid_q[idx_s]),
        .acc_way_i (acc_way_s),
        .victim_o  (victim_s),
        .plru_o    (plru_next_s)
    );

    // Next-state and strobes; read hits complete combinationally in IDLE.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        readData    = 32'd0;
        sramRdEn    = 1'b0;
        sramWrEn    = 1'b0;
        flush_all_s = 1'b0;
        plru_we_s   = 1'b0;
        fill_we_s   = 1'b0;
        wr_hit_we_s = 1'b0;
        hit_inc_s   = 1'b0;
        miss_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    flush_all_s = 1'b1;
                end else if (wrEn) begin
                    state_d = WR;
                end else if (rdEn) begin
                    if (hit_s) begin
                        ready     = 1'b1;
                        readData  = hit_word_s;
                        plru_we_s = 1'b1;
                        hit_inc_s = 1'b1;
                    end else begin
                        state_d = RD_MISS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_MISS: begin
                sramRdEn = 1'b1;
                if (sramReady) begin
                    ready      = 1'b1;
                    readData   = fill_word_s;
                    fill_we_s  = 1'b1;
                    plru_we_s  = 1'b1;
                    miss_inc_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = RD_MISS;
                end
            end
            WR: begin
                sramWrEn = 1'b1;
                if (sramReady) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                    if (hit_s) begin
                        wr_hit_we_s = 1'b1;
                        plru_we_s   = 1'b1;
                    end else begin
                        wr_hit_we_s = 1'b0;
                    end
                end else begin
                    state_d = WR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Line data and tags carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_q[victim_s][idx_s] <= sramReadData;
            tag_q[victim_s][idx_s]  <= tag_s;
        end else if (wr_hit_we_s) begin
            data_q[hit_way_s][idx_s] <= wr_line_s;
        end
    end

    // Valid and replacement state; flush clears validity but keeps the trees.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (flush_all_s) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (fill_we_s) begin
                valid_q[idx_s][victim_s] <= 1'b1;
            end
            if (plru_we_s) begin
                plru_q[idx_s] <= plru_next_s;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Read-only statistics; writes are deliberately not counted.
    always_comb begin
        hit_cnt_d  = hit_inc_s  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
        miss_cnt_d = miss_inc_s ? sat_inc(miss_cnt_q) : miss_cnt_q;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = hit_inc_s ^ miss_inc_s;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: a 2-way and a 4-way instance driven
// through hand-computed read/write/flush/reset sequences.
module tb_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address       [2];
    logic [31:0] write_data    [2];
    logic        rd_en         [2];
    logic        wr_en         [2];
    logic        flush         [2];
    logic [31:0] read_data     [2];
    logic        ready         [2];
    logic [31:0] sram_addr     [2];
    logic [31:0] sram_wdata    [2];
    logic        sram_wr_en    [2];
    logic        sram_rd_en    [2];
    logic [63:0] sram_rdata    [2];
    logic        sram_ready    [2];
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt       [2];
    logic [31:0] miss_cnt      [2];
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.WAYS(2), .SETS(64), .TAG_W(10)) dut2 (
        .clk(clk), .rst(rst), .address(address[0]), .writeData(write_data[0]),
        .rdEn(rd_en[0]), .wrEn(wr_en[0]), .flush(flush[0]),
        .readData(read_data[0]), .ready(ready[0]),
        .sramAddress(sram_addr[0]), .sramWriteData(sram_wdata[0]),
        .sramWrEn(sram_wr_en[0]), .sramRdEn(sram_rd_en[0]),
        .sramReadData(sram_rdata[0]), .sramReady(sram_ready[0])
`ifdef CACHE_STATS_EN
        , .hitCount(hit_cnt[0]), .missCount(miss_cnt[0])
`endif
    );

    assoc_cache_ctrl #(.WAYS(4), .SETS(64), .TAG_W(10)) dut4 (
        .clk(clk), .rst(rst), .address(address[1]), .writeData(write_data[1]),
        .rdEn(rd_en[1]), .wrEn(wr_en[1]), .flush(flush[1]),
        .readData(read_data[1]), .ready(ready[1]),
        .sramAddress(sram_addr[1]), .sramWriteData(sram_wdata[1]),
        .sramWrEn(sram_wr_en[1]), .sramRdEn(sram_rd_en[1]),
        .sramReadData(sram_rdata[1]), .sramReady(sram_ready[1])
`ifdef CACHE_STATS_EN
        , .hitCount(hit_cnt[1]), .missCount(miss_cnt[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SETS=64 puts the index in [8:3] and the tag from bit 9 upwards.
    function automatic logic [31:0] mk_addr(input int t, input int idx, input int w);
        return 32'((t << 9) | (idx << 3) | (w << 2));
    endfunction

    function automatic logic [63:0] mk_line(input int t);
        return {32'hB000_0000 | 32'(t), 32'hA000_0000 | 32'(t)};
    endfunction

    // Plays the SRAM controller: nwait busy cycles, then a one-cycle sramReady.
    task automatic sram_finish(input int u, input logic [63:0] line, input logic [31:0] exp_word,
                               input int nwait, input logic is_wr, input string tag);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            check_eq({tag, "_strobe"}, 64'(is_wr ? sram_wr_en[u] : sram_rd_en[u]), 64'd1);
            check_eq({tag, "_other"}, 64'(is_wr ? sram_rd_en[u] : sram_wr_en[u]), 64'd0);
            check_eq({tag, "_busy"}, 64'(ready[u]), 64'd0);
        end
        @(posedge clk);
        #1;
        sram_ready[u] = 1'b1;
        sram_rdata[u] = line;
        @(negedge clk);
        check_eq({tag, "_done"}, 64'(ready[u]), 64'd1);
        check_eq({tag, "_strobe_last"}, 64'(is_wr ? sram_wr_en[u] : sram_rd_en[u]), 64'd1);
        check_eq({tag, "_data"}, 64'(read_data[u]), 64'(is_wr ? 32'd0 : exp_word));
        @(posedge clk);
        #1;
        sram_ready[u] = 1'b0;
        rd_en[u]      = 1'b0;
        wr_en[u]      = 1'b0;
        @(negedge clk);
        check_eq({tag, "_drop"}, 64'(is_wr ? sram_wr_en[u] : sram_rd_en[u]), 64'd0);
        check_eq({tag, "_idle"}, 64'(ready[u]), 64'd0);
    endtask

    task automatic do_read(input int u, input logic [31:0] addr, input logic exp_hit,
                           input logic [63:0] line, input logic [31:0] exp_word, input string tag);
        @(posedge clk);
        #1;
        address[u] = addr;
        rd_en[u]   = 1'b1;
        @(negedge clk);
        check_eq({tag, "_hit"}, 64'(ready[u]), 64'(exp_hit));
        if (exp_hit) begin
            check_eq({tag, "_hitdata"}, 64'(read_data[u]), 64'(exp_word));
            @(posedge clk);
            #1;
            rd_en[u] = 1'b0;
        end else begin
            check_eq({tag, "_nodata"}, 64'(read_data[u]), 64'd0);
            @(posedge clk);
            sram_finish(u, line, exp_word, 2, 1'b0, tag);
        end
    endtask

    task automatic do_write(input int u, input logic [31:0] addr, input logic [31:0] data,
                            input string tag);
        @(posedge clk);
        #1;
        address[u]    = addr;
        write_data[u] = data;
        wr_en[u]      = 1'b1;
        @(negedge clk);
        check_eq({tag, "_req"}, 64'(ready[u]), 64'd0);
        check_eq({tag, "_saddr"}, 64'(sram_addr[u]), 64'(addr));
        check_eq({tag, "_swdata"}, 64'(sram_wdata[u]), 64'(data));
        @(posedge clk);
        sram_finish(u, 64'd0, 32'd0, 2, 1'b1, tag);
    endtask

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            address[u]    = 32'd0;
            write_data[u] = 32'd0;
            rd_en[u]      = 1'b0;
            wr_en[u]      = 1'b0;
            flush[u]      = 1'b0;
            sram_rdata[u] = 64'd0;
            sram_ready[u] = 1'b0;
        end
        @(negedge clk);
        check_eq("rst_ready", 64'(ready[0]), 64'd0);
        check_eq("rst_rdata", 64'(read_data[0]), 64'd0);
        check_eq("rst_srd", 64'(sram_rd_en[0]), 64'd0);
        check_eq("rst_swr", 64'(sram_wr_en[0]), 64'd0);
        check_eq("rst_ready4", 64'(ready[1]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First fill and a same-line reread of the other word.
        do_read(0, 32'h0000_0010, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD, "fill10");
        do_read(0, 32'h0000_0014, 1'b1, 64'd0, 32'hAAAA_BBBB, "hit14");

        // Two-way LRU: tag 2 is the victim once tag 1 has been re-touched.
        do_read(0, mk_addr(1, 3, 0), 1'b0, mk_line(1), 32'hA000_0001, "w2_t1");
        do_read(0, mk_addr(2, 3, 0), 1'b0, mk_line(2), 32'hA000_0002, "w2_t2");
        do_read(0, mk_addr(1, 3, 0), 1'b1, 64'd0, 32'hA000_0001, "w2_t1hit");
        do_read(0, mk_addr(3, 3, 0), 1'b0, mk_line(3), 32'hA000_0003, "w2_t3");
        do_read(0, mk_addr(1, 3, 1), 1'b1, 64'd0, 32'hB000_0001, "w2_t1keep");
        do_read(0, mk_addr(2, 3, 0), 1'b0, mk_line(2), 32'hA000_0002, "w2_t2gone");

        // Four-way tree: fill set 5, touch ways 0,2,1 -> next victim is way 3.
        for (int t = 1; t <= 4; t++) begin
            do_read(1, mk_addr(t, 5, 0), 1'b0, mk_line(t), 32'hA000_0000 | 32'(t), "w4_fill");
        end
        do_read(1, mk_addr(1, 5, 0), 1'b1, 64'd0, 32'hA000_0001, "w4_acc0");
        do_read(1, mk_addr(3, 5, 0), 1'b1, 64'd0, 32'hA000_0003, "w4_acc2");
        do_read(1, mk_addr(2, 5, 0), 1'b1, 64'd0, 32'hA000_0002, "w4_acc1");
        do_read(1, mk_addr(5, 5, 0), 1'b0, mk_line(5), 32'hA000_0005, "w4_t5");
        do_read(1, mk_addr(1, 5, 0), 1'b1, 64'd0, 32'hA000_0001, "w4_keep0");
        do_read(1, mk_addr(2, 5, 0), 1'b1, 64'd0, 32'hA000_0002, "w4_keep1");
        do_read(1, mk_addr(3, 5, 0), 1'b1, 64'd0, 32'hA000_0003, "w4_keep2");
        do_read(1, mk_addr(5, 5, 1), 1'b1, 64'd0, 32'hB000_0005, "w4_t5hit");
        do_read(1, mk_addr(4, 5, 0), 1'b0, mk_line(4), 32'hA000_0004, "w4_t4gone");

        // Write hit updates one word; write miss does not allocate.
        do_write(0, 32'h0000_0014, 32'h1234_5678, "wr_hit");
        do_read(0, 32'h0000_0014, 1'b1, 64'd0, 32'h1234_5678, "wr_hit_rd");
        do_read(0, 32'h0000_0010, 1'b1, 64'd0, 32'hCCCC_DDDD, "wr_hit_oth");
        do_write(0, mk_addr(7, 2, 0), 32'hDEAD_BEEF, "wr_miss");
        do_read(0, mk_addr(7, 2, 0), 1'b0, 64'h7777_7777_5555_5555, 32'h5555_5555, "wr_miss_rd");

        // Flush beats a pending read; the old line then misses.
        @(posedge clk);
        #1;
        address[0] = 32'h0000_0010;
        rd_en[0]   = 1'b1;
        flush[0]   = 1'b1;
        @(negedge clk);
        check_eq("flush_noready", 64'(ready[0]), 64'd0);
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        rd_en[0] = 1'b0;
        do_read(0, 32'h0000_0010, 1'b0, 64'h1234_5678_CCCC_DDDD, 32'hCCCC_DDDD, "flush_miss");

        // Reset in the middle of a miss drops the strobe immediately.
        @(posedge clk);
        #1;
        address[0] = mk_addr(9, 10, 0);
        rd_en[0]   = 1'b1;
        @(negedge clk);
        check_eq("rstmid_req", 64'(ready[0]), 64'd0);
        @(negedge clk);
        check_eq("rstmid_srd", 64'(sram_rd_en[0]), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rstmid_drop", 64'(sram_rd_en[0]), 64'd0);
        check_eq("rstmid_ready", 64'(ready[0]), 64'd0);
        rd_en[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Counters restart from reset: two misses then three hits.
        do_read(0, 32'h0000_0010, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD, "post_rst10");
        do_read(0, mk_addr(9, 10, 0), 1'b0, mk_line(9), 32'hA000_0009, "post_rst_re");
        do_read(0, 32'h0000_0014, 1'b1, 64'd0, 32'hAAAA_BBBB, "st_hit1");
        do_read(0, 32'h0000_0010, 1'b1, 64'd0, 32'hCCCC_DDDD, "st_hit2");
        do_read(0, mk_addr(9, 10, 1), 1'b1, 64'd0, 32'hB000_0009, "st_hit3");
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check_eq("stat_hits", 64'(hit_cnt[0]), 64'd3);
        check_eq("stat_miss", 64'(miss_cnt[0]), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/assoc_cache_ctrl.md
# assoc_cache_ctrl

Parametrised N-way set-associative, write-through, no-write-allocate data cache between the memory stage and the SRAM controller. Generalises the fixed 2-way/64-set cache to configurable ways and sets, adds tree pseudo-LRU replacement, a hit-update on writes, a one-cycle flush, and optional hit/miss statistics. Lines are 64 bits (two 32-bit words), matching the SRAM controller's 64-bit read path.

## Interface
- WAYS, 2: associativity; power of two, 2..8
- SETS, 64: number of sets; power of two, 16..256
- TAG_W, 10: stored tag width; address bits above the tag are ignored
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- address  in  32  byte address; [2] selects the word, [INDEX_W+2:3] is the index, next TAG_W bits are the tag
- writeData  in  32  store data
- rdEn / wrEn  in  1  request strobes; held stable until ready; both high is treated as a write
- flush  in  1  invalidate all lines
- readData  out  32  load data; valid only while ready is high, 0 otherwise
- ready  out  1  request completes this cycle
- sramAddress  out  32  equals address
- sramWriteData  out  32  equals writeData
- sramWrEn / sramRdEn  out  1  SRAM controller strobes
- sramReadData  in  64  fetched line
- sramReady  in  1  SRAM controller completion pulse

## Operation
- Storage: data[WAYS][SETS] 64 b, tag[WAYS][SETS] TAG_W, valid[WAYS][SETS], plru[SETS] (WAYS-1 bits). Only valid and plru are reset; data and tag are not.
- States: IDLE, RD_MISS, WR.
- IDLE:
  - flush high wins over any request and clears all valid bits in one cycle; plru is untouched; the request is served next cycle.
  - Read hit: ready=1 in the same cycle, readData comes from the hit way, plru is updated, and the state stays IDLE.
  - Read miss: go to RD_MISS.
  - Write: go to WR.
- RD_MISS: sramRdEn=1 until sramReady.
  - On sramReady: ready=1; readData is the selected word of sramReadData.
  - The line, tag and valid bit are written into the victim way, plru is updated, and the state returns to IDLE.
- WR: sramWrEn=1 until sramReady.
  - On sramReady: ready=1.
  - On a hit, the selected word is written into that way's line and plru is updated.
  - A miss does not allocate. Return to IDLE.
- Hit is re-evaluated in WR at completion, so a line filled earlier is honoured.
- Victim: the lowest-numbered invalid way; if all are valid, walk the plru tree (bit 0 = go left).
- plru update on an access to way w: every node on w's path is set to point away from w.
- For WAYS=2 the tree reduces to a single LRU bit.
- Request signals are not sampled in the ready cycle; the requester drops or changes them after ready.

## Timing
- Read hit: 0-cycle latency; ready is combinational from address/rdEn in IDLE. Back-to-back hits complete one per cycle.
- Read miss / write: one cycle longer than the SRAM controller. The strobe is asserted from the cycle after the request through the sramReady cycle inclusive, then dropped.
- Reset values: state IDLE, ready 0, readData 0, sramRdEn 0, sramWrEn 0, all valid 0, all plru 0.
- Reset mid-miss or mid-write: strobes drop immediately (asynchronous). The transaction is abandoned, nothing is written to the arrays, and the requester must reissue.
- flush during RD_MISS/WR: ignored; the requester holds flush until an IDLE cycle.

## Configuration
- CACHE_STATS_EN defined: adds outputs hitCount and missCount (32 b each).
  - A read hit increments hitCount in its ready cycle; a read miss increments missCount in its fill cycle.
  - Writes are not counted. Counters saturate at 0xFFFFFFFF and clear only on reset.
- CACHE_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package cache_pkg:
  - the state enum (IDLE, RD_MISS, WR) and default parameter values;
  - derived widths INDEX_W = $clog2(SETS) and PLRU_W = WAYS-1.
- Sub-module plru_tree: combinational; takes a set's plru bits, the valid vector and the accessed way, and returns the victim way and the next plru bits. It is instantiated once, on the indexed set.

## Test plan
- Reset, then read 0x0000_0010 -> RD_MISS. sramRdEn high until sramReady with sramReadData=0xAAAA_BBBB_CCCC_DDDD. readData=0xCCCC_DDDD and ready=1 in that cycle. An immediate reread of 0x14 hits in 0 cycles with 0xAAAA_BBBB.
- WAYS=2: reads of tags 1, 2, then 1, then tag 3 at the same index. Tag 2's line is evicted; a reread of tag 1 hits and a reread of tag 2 misses.
- WAYS=4: fill all four ways of set 5, then access ways 0, 2 and 1. The next miss in set 5 replaces way 3.
- Write hit to 0x14 with 0x1234_5678: sramWrEn held until sramReady, ready=1. A later read of 0x14 hits with 0x1234_5678. A write miss to a new tag leaves that tag missing on a later read.
- flush in IDLE with rdEn high: no ready that cycle; the following read of a previously cached address misses.
- rst low during RD_MISS before sramReady: sramRdEn drops at once and the state is IDLE. With CACHE_STATS_EN, after 3 hits and 2 misses the counters read hitCount=3 and missCount=2.
